// File: rtl/uart_fifo.sv
// uart_fifo: UART with TX and RX FIFOs, 16x oversampling and first-word-fall-through RX.
// Frames are start + data_bits + stop. When the macro UART_PARITY_EN is defined, a parity bit
// is added after the data bits and the parameter parity_odd (0 = even) selects its sense.
module uart_fifo #(
    parameter int unsigned freq_hz         = 50000000,
    parameter int unsigned baud            = 115200,
    parameter int unsigned data_bits       = 8,
    parameter int unsigned fifo_depth_log2 = 4
`ifdef UART_PARITY_EN
    ,
    parameter bit          parity_odd      = 1'b0
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     uart_rxd,
    output logic                     uart_txd,
    input  logic [data_bits-1:0]     tx_data,
    input  logic                     tx_wr,
    output logic                     tx_full,
    output logic                     tx_busy,
    output logic [data_bits-1:0]     rx_data,
    output logic                     rx_avail,
    input  logic                     rx_ack,
    output logic [fifo_depth_log2:0] rx_level,
    output logic                     rx_error,
    output logic                     rx_overrun
);

    localparam int unsigned Depth   = 1 << fifo_depth_log2;
    localparam int unsigned LvlW    = fifo_depth_log2 + 1;
    localparam int unsigned Divisor = freq_hz / (baud * 16);
    localparam int unsigned DivW    = (Divisor > 1) ? $clog2(Divisor) : 1;

    localparam logic [DivW-1:0] DivLast  = DivW'(Divisor - 1);
    localparam logic [LvlW-1:0] DepthCnt = LvlW'(Depth);
    localparam logic [3:0]      LastBit  = 4'(data_bits - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_PARITY_EN
        ,
        StParity
`endif
    } state_e;

    // ------------------------------------------------------------------ tick
    logic [DivW-1:0] div_q;
    logic            tick;

    assign tick = (div_q == DivLast);

    // Free-running 16x oversample divider
    always_ff @(posedge clk) begin
        if (!reset_n)  div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + 1'b1;
    end

    // ------------------------------------------------------------------ TX FIFO
    logic [data_bits-1:0]       tx_mem [Depth];
    logic [fifo_depth_log2-1:0] tx_wptr_q, tx_rptr_q;
    logic [LvlW-1:0]            tx_cnt_q;
    logic                       tx_push, tx_pop, tx_empty;
    logic [data_bits-1:0]       tx_head;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == DepthCnt);
    // A push while full still lands when the head leaves in the same cycle
    assign tx_push  = tx_wr && (!tx_full || tx_pop);
    assign tx_head  = tx_mem[tx_rptr_q];

    // TX storage write (no reset on the array)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= tx_data;
    end

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + LvlW'(tx_push) - LvlW'(tx_pop);
        end
    end

    // ------------------------------------------------------------------ TX FSM
    state_e               tx_state_q, tx_state_d;
    logic [3:0]           tx_tick_q, tx_tick_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [data_bits-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_load;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_busy = !tx_empty || (tx_state_q != StIdle);

    // TX state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_q <= StIdle;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // TX next state and line output; a frame ending with data waiting loads the next with no gap
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        uart_txd   = 1'b1;
        unique case (tx_state_q)
            StIdle: tx_load = !tx_empty;
            StStart: begin
                uart_txd = 1'b0;
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_bit_d   = '0;
                        tx_state_d = StData;
                    end
                end
            end
            StData: begin
                uart_txd = tx_shift_q[0];
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 4'd1;
                        if (tx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
                            tx_state_d = StParity;
`else
                            tx_state_d = StStop;
`endif
                        end
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                uart_txd = tx_par_q;
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) tx_state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_state_d = StIdle;
                        tx_load    = !tx_empty;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_tick_d  = '0;
            tx_state_d = StStart;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_head) ^ parity_odd;
`endif
        end
    end

    // ------------------------------------------------------------------ RX sync
    logic [1:0] rx_sync_q;
    logic       rx_prev_q;
    logic       rx_line, rx_fall;

    assign rx_line = rx_sync_q[1];
    assign rx_fall = rx_prev_q && !rx_line;

    // Two-flop synchroniser plus edge history; idle-high after reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rxd};
            rx_prev_q <= rx_line;
        end
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [data_bits-1:0]       rx_mem [Depth];
    logic [fifo_depth_log2-1:0] rx_wptr_q, rx_rptr_q;
    logic [LvlW-1:0]            rx_cnt_q;
    logic                       rx_push, rx_pop, rx_empty, rx_can_push;
    logic [data_bits-1:0]       rx_shift_q, rx_shift_d;

    assign rx_empty    = (rx_cnt_q == '0);
    assign rx_pop      = rx_ack && !rx_empty;
    assign rx_can_push = (rx_cnt_q != DepthCnt) || rx_pop;
    assign rx_avail    = !rx_empty;
    assign rx_level    = rx_cnt_q;
    assign rx_data     = rx_mem[rx_rptr_q];

    // RX storage write (no reset on the array)
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    // RX pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            rx_cnt_q <= rx_cnt_q + LvlW'(rx_push) - LvlW'(rx_pop);
        end
    end

    // ------------------------------------------------------------------ RX FSM
    state_e     rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic       rx_par_bad;
`ifdef UART_PARITY_EN
    logic       rx_perr_q, rx_perr_d;
    assign rx_par_bad = rx_perr_q;
`else
    assign rx_par_bad = 1'b0;
`endif

    // RX state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q <= StIdle;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
`ifdef UART_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    // RX next state; samples land mid-bit, 8 ticks after the start edge then every 16
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_perr_q;
`endif
        rx_push    = 1'b0;
        rx_error   = 1'b0;
        rx_overrun = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_fall) begin
                    rx_tick_d  = '0;
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd7) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_line ? StIdle : StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_shift_d = {rx_line, rx_shift_q[data_bits-1:1]};
                        rx_bit_d   = rx_bit_q + 4'd1;
                        if (rx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
                            rx_state_d = StParity;
`else
                            rx_state_d = StStop;
`endif
                        end
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_perr_d  = rx_line ^ (^rx_shift_q) ^ parity_odd;
                        rx_state_d = StStop;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_state_d = StIdle;
                        if (!rx_line || rx_par_bad) rx_error   = 1'b1;
                        else if (!rx_can_push)      rx_overrun = 1'b1;
                        else                        rx_push    = 1'b1;
                    end
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: expected bytes are queued at stimulus time and popped by
// independent TX-line and RX-port monitors. A fast baud keeps frames short.
`timescale 1ns/1ps
module tb_uart_fifo;

    localparam int FREQ   = 50000000;
    localparam int BAUD   = 1400000;
    localparam int DBITS  = 8;
    localparam int DLOG   = 4;
    localparam int DEPTH  = 1 << DLOG;
    localparam int DIV    = FREQ / (BAUD * 16);
    localparam int BITC   = 16 * DIV;
`ifdef UART_PARITY_EN
    localparam bit PODD   = 1'b0;
    localparam int FBITS  = DBITS + 3;
`else
    localparam int FBITS  = DBITS + 2;
`endif
    localparam int FRAMEC = FBITS * BITC;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             uart_rxd, uart_txd;
    logic [DBITS-1:0] tx_data;
    logic             tx_wr, tx_full, tx_busy;
    logic [DBITS-1:0] rx_data;
    logic             rx_avail, rx_ack, rx_error, rx_overrun;
    logic [DLOG:0]    rx_level;

    logic loop_en, drv_rxd, auto_ack, tx_mon_en, ack_mon, ack_man;

    int checks = 0;
    int errors = 0;
    int n_err  = 0;
    int n_ovr  = 0;

    logic [DBITS-1:0] exp_rx[$];
    logic [DBITS-1:0] exp_tx[$];

    always #5 clk = ~clk;

    assign uart_rxd = loop_en ? uart_txd : drv_rxd;
    assign rx_ack   = ack_mon | ack_man;

    uart_fifo #(
        .freq_hz        (FREQ),
        .baud           (BAUD),
        .data_bits      (DBITS),
        .fifo_depth_log2(DLOG)
`ifdef UART_PARITY_EN
        ,
        .parity_odd     (PODD)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_rxd  (uart_rxd),
        .uart_txd  (uart_txd),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_full   (tx_full),
        .tx_busy   (tx_busy),
        .rx_data   (rx_data),
        .rx_avail  (rx_avail),
        .rx_ack    (rx_ack),
        .rx_level  (rx_level),
        .rx_error  (rx_error),
        .rx_overrun(rx_overrun)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [FBITS-1:0] mk_frame(input logic [DBITS-1:0] d, input logic stop);
`ifdef UART_PARITY_EN
        return {stop, (^d) ^ PODD, d, 1'b0};
`else
        return {stop, d, 1'b0};
`endif
    endfunction

    // Pulse counters
    always @(negedge clk) begin
        if (rx_error)   n_err++;
        if (rx_overrun) n_ovr++;
    end

    // RX monitor: pops the DUT head whenever presented and compares to the scoreboard
    initial begin
        ack_mon = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_mon) ack_mon = 1'b0;
            else if (auto_ack && reset_n && rx_avail && ($urandom_range(0, 3) != 0)) begin
                chk("rx_expected_pending", 32'(exp_rx.size() != 0), 32'd1);
                if (exp_rx.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                ack_mon = 1'b1;
            end
        end
    end

    // TX line monitor: decodes frames at mid-bit and compares to the scoreboard
    initial begin
        logic             prev;
        logic [DBITS-1:0] d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_mon_en && prev && !uart_txd) begin
                repeat (BITC / 2) @(negedge clk);
                chk("tx_start_bit", 32'(uart_txd), 32'd0);
                for (int i = 0; i < DBITS; i++) begin
                    repeat (BITC) @(negedge clk);
                    d[i] = uart_txd;
                end
`ifdef UART_PARITY_EN
                repeat (BITC) @(negedge clk);
                chk("tx_parity_bit", 32'(uart_txd), 32'((^d) ^ PODD));
`endif
                repeat (BITC) @(negedge clk);
                chk("tx_stop_bit", 32'(uart_txd), 32'd1);
                chk("tx_expected_pending", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) chk("tx_data", 32'(d), 32'(exp_tx.pop_front()));
            end
            prev = uart_txd;
        end
    end

    task automatic push_tx(input logic [DBITS-1:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic man_ack();
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
    endtask

    task automatic send_bits(input logic [FBITS-1:0] bits);
        for (int i = 0; i < FBITS; i++) begin
            drv_rxd = bits[i];
            repeat (BITC) @(negedge clk);
        end
        drv_rxd = 1'b1;
        repeat (2 * BITC) @(negedge clk);
    endtask

    task automatic wait_level(input string name, input int lvl, input int budget);
        int n = 0;
        while (int'(rx_level) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_tx_idle(input string name, input int budget);
        int n = 0;
        while ((tx_busy || exp_tx.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((tx_busy || rx_avail || exp_tx.size() != 0 || exp_rx.size() != 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    // Watchdog
    initial begin
        repeat (90000) @(negedge clk);
        $display("FAIL watchdog: bench did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DBITS-1:0] d, first;
        logic             stop;
        int               e0, o0, exp_e;

        reset_n   = 1'b0;
        tx_wr     = 1'b0;
        tx_data   = '0;
        drv_rxd   = 1'b1;
        loop_en   = 1'b1;
        auto_ack  = 1'b1;
        tx_mon_en = 1'b1;
        ack_man   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_txd",        32'(uart_txd),   32'd1);
        chk("reset_tx_full",    32'(tx_full),    32'd0);
        chk("reset_tx_busy",    32'(tx_busy),    32'd0);
        chk("reset_rx_avail",   32'(rx_avail),   32'd0);
        chk("reset_rx_level",   32'(rx_level),   32'd0);
        chk("reset_rx_error",   32'(rx_error),   32'd0);
        chk("reset_rx_overrun", 32'(rx_overrun), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed loopback, manual pops
        auto_ack = 1'b0;
        exp_tx.push_back(8'h55);
        exp_tx.push_back(8'hA3);
        push_tx(8'h55);
        push_tx(8'hA3);
        wait_level("lb_wait_two", 2, 3 * FRAMEC);
        chk("lb_level2", 32'(rx_level), 32'd2);
        chk("lb_head0",  32'(rx_data),  32'h55);
        man_ack();
        chk("lb_level1", 32'(rx_level), 32'd1);
        chk("lb_head1",  32'(rx_data),  32'hA3);
        man_ack();
        chk("lb_level0", 32'(rx_level), 32'd0);
        chk("lb_avail0", 32'(rx_avail), 32'd0);
        wait_drain("lb_drain", 2 * FRAMEC);

        // Randomised loopback bursts
        auto_ack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                d = DBITS'($urandom);
                exp_tx.push_back(d);
                exp_rx.push_back(d);
                push_tx(d);
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
            wait_drain("rand_drain", 10 * FRAMEC);
        end

        // TX fill: shifter takes the first byte, FIFO holds 16 more, the next is dropped
        loop_en = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            d = DBITS'($urandom);
            if (i < DEPTH + 1) exp_tx.push_back(d);
            push_tx(d);
            if (i == DEPTH - 1) chk("fill_not_full", 32'(tx_full), 32'd0);
            if (i == DEPTH)     chk("fill_full",     32'(tx_full), 32'd1);
        end
        chk("fill_still_full", 32'(tx_full), 32'd1);
        chk("fill_busy",       32'(tx_busy), 32'd1);
        wait_drain("fill_drain", (DEPTH + 3) * FRAMEC);
        chk("fill_empty_after", 32'(tx_full), 32'd0);

        // Framing: bad stop bit, glitch rejection, random stop bits
        e0 = n_err;
        send_bits(mk_frame(8'h3C, 1'b0));
        chk("frame_err_pulse", 32'(n_err - e0), 32'd1);
        chk("frame_no_push",   32'(rx_level),   32'd0);
        exp_rx.push_back(8'h3C);
        send_bits(mk_frame(8'h3C, 1'b1));
        wait_drain("frame_good_drain", 2 * FRAMEC);
        e0 = n_err;
        drv_rxd = 1'b0;
        repeat (4) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (2 * BITC) @(negedge clk);
        chk("glitch_no_err",   32'(n_err - e0), 32'd0);
        chk("glitch_no_data",  32'(rx_level),   32'd0);
        exp_e = 0;
        e0    = n_err;
        for (int k = 0; k < 4; k++) begin
            d    = DBITS'($urandom);
            stop = 1'($urandom_range(0, 1));
            if (stop) exp_rx.push_back(d);
            else      exp_e++;
            send_bits(mk_frame(d, stop));
        end
        wait_drain("frame_rand_drain", 2 * FRAMEC);
        chk("frame_rand_errs", 32'(n_err - e0), 32'(exp_e));

        // Overrun: 17 looped frames, no pops
        loop_en  = 1'b1;
        auto_ack = 1'b0;
        o0       = n_ovr;
        first    = '0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = DBITS'($urandom);
            if (i == 0) first = d;
            exp_tx.push_back(d);
            if (i < DEPTH) exp_rx.push_back(d);
            push_tx(d);
        end
        wait_tx_idle("ovr_tx_done", (DEPTH + 3) * FRAMEC);
        chk("ovr_level",  32'(rx_level),    32'(DEPTH));
        chk("ovr_pulse",  32'(n_ovr - o0),  32'd1);
        chk("ovr_head",   32'(rx_data),     32'(first));
        auto_ack = 1'b1;
        wait_drain("ovr_drain", 4 * FRAMEC);
        chk("ovr_level0", 32'(rx_level), 32'd0);

        // Reset in the middle of data bit 3 (0xA5 has bit 3 low)
        tx_mon_en = 1'b0;
        e0 = n_err;
        push_tx(8'hA5);
        begin
            int n = 0;
            while (uart_txd && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rst_start_seen", 32'(n < 20), 32'd1);
        end
        repeat (4 * BITC + BITC / 2) @(negedge clk);
        chk("rst_pre_bit3", 32'(uart_txd), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_txd_high", 32'(uart_txd), 32'd1);
        chk("rst_tx_busy",  32'(tx_busy),  32'd0);
        chk("rst_rx_level", 32'(rx_level), 32'd0);
        reset_n = 1'b1;
        repeat (FRAMEC) @(negedge clk);
        chk("rst_quiet_avail", 32'(rx_avail),    32'd0);
        chk("rst_quiet_err",   32'(n_err - e0),  32'd0);
        tx_mon_en = 1'b1;
        exp_tx.push_back(8'h81);
        exp_rx.push_back(8'h81);
        push_tx(8'h81);
        wait_drain("rst_after_drain", 3 * FRAMEC);

`ifdef UART_PARITY_EN
        // Even parity: 0x07 needs a parity bit of 1
        loop_en = 1'b0;
        e0 = n_err;
        send_bits({1'b1, 1'b0, 8'h07, 1'b0});
        chk("par_bad_err",    32'(n_err - e0), 32'd1);
        chk("par_bad_nopush", 32'(rx_level),   32'd0);
        exp_rx.push_back(8'h07);
        send_bits({1'b1, 1'b1, 8'h07, 1'b0});
        wait_drain("par_good_drain", 2 * FRAMEC);
        chk("par_good_noerr", 32'(n_err - e0), 32'd1);
        loop_en = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
